// File: rtl/vote_pkg.sv
`default_nettype none
// ==== vote_pkg : session FSM state encoding and one-hot helper -- rev 1.0 ====
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MAX_ONEHOT_W = 64;

  // Callers zero-extend narrower ballots; exactly one bit set means a valid vote.
  function automatic logic is_onehot(input logic [MAX_ONEHOT_W-1:0] v);
    return (v != '0) && ((v & (v - MAX_ONEHOT_W'(1))) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vote_max_scan.sv
`default_nettype none
// ==== vote_max_scan : one-candidate-per-cycle argmax with tie flag -- rev 1.0 ====
module vote_max_scan #(
  parameter int CNT_W   = 3,
  parameter int IDX_W   = 2,
  parameter int TIE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             first,
  input  logic [IDX_W-1:0] idx,
  input  logic [CNT_W-1:0] val,
  output logic [CNT_W-1:0] nxt_max,
  output logic [IDX_W-1:0] nxt_idx,
  output logic             nxt_tie
);

  logic [CNT_W-1:0] max_q;
  logic [IDX_W-1:0] idx_q;
  logic             tie_q;

  // The final comparison's outcome is exposed combinationally so the caller
  // can capture the result on the same edge that ends the scan.
  always_comb begin
    nxt_max = max_q;
    nxt_idx = idx_q;
    nxt_tie = tie_q;
    if (first || (val > max_q)) begin
      nxt_max = val;
      nxt_idx = idx;
      nxt_tie = 1'b0;
    end else if (val == max_q) begin
      nxt_tie = 1'b1;
      if (TIE_LOW == 0) nxt_idx = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      idx_q <= '0;
      tie_q <= 1'b0;
    end else if (step) begin
      max_q <= nxt_max;
      idx_q <= nxt_idx;
      tie_q <= nxt_tie;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vote_session_tally.sv
`default_nettype none
// ==== vote_session_tally : session-based plurality voter with result handshake -- rev 1.0 ====
module vote_session_tally
  import vote_pkg::*;
#(
  parameter int NUM_VOTERS = 5,
  parameter int NUM_CAND   = 3,
  parameter int TIE_LOW    = 0,
  parameter int CNT_W      = $clog2(NUM_VOTERS + 1),
  parameter int IDX_W      = $clog2(NUM_CAND)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           close,
  input  logic [NUM_VOTERS-1:0]          ballot_valid,
  input  logic [NUM_VOTERS*NUM_CAND-1:0] ballot,
  output logic                           busy,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [NUM_CAND-1:0]            winner_onehot,
  output logic [IDX_W-1:0]               winner_idx,
  output logic [CNT_W-1:0]               winner_votes,
  output logic                           tie,
  output logic [CNT_W-1:0]               spoiled_cnt,
  output logic                           dup_err
);

  state_t                state;
  logic [CNT_W-1:0]      tally [NUM_CAND];
  logic [CNT_W-1:0]      inc   [NUM_CAND];
  logic [CNT_W-1:0]      spoil_inc;
  logic [NUM_VOTERS-1:0] voted;
  logic [NUM_VOTERS-1:0] accept;
  logic [NUM_VOTERS-1:0] is_oh;
  logic                  all_cast;
  logic [IDX_W-1:0]      scan_idx;
  logic                  scan_last;
  logic [CNT_W-1:0]      scan_val;
  logic [CNT_W-1:0]      scan_max;
  logic [IDX_W-1:0]      scan_win;
  logic                  scan_tie;

  genvar gv;
  generate
    for (gv = 0; gv < NUM_VOTERS; gv++) begin : g_onehot
      assign is_oh[gv] = is_onehot(MAX_ONEHOT_W'(ballot[gv*NUM_CAND +: NUM_CAND]));
    end
  endgenerate

  assign accept    = ballot_valid & ~voted;
  assign all_cast  = &(voted | ballot_valid);
  assign scan_last = (scan_idx == IDX_W'(NUM_CAND - 1));

  // Per-candidate counts of this cycle's first-time one-hot ballots.
  always_comb begin
    spoil_inc = '0;
    for (int c = 0; c < NUM_CAND; c++) inc[c] = '0;
    for (int v = 0; v < NUM_VOTERS; v++) begin
      if (accept[v] && !is_oh[v]) spoil_inc = spoil_inc + CNT_W'(1);
      for (int c = 0; c < NUM_CAND; c++) begin
        if (accept[v] && is_oh[v] && ballot[v*NUM_CAND + c]) inc[c] = inc[c] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    scan_val = '0;
    for (int c = 0; c < NUM_CAND; c++) begin
      if (IDX_W'(c) == scan_idx) scan_val = tally[c];
    end
  end

  vote_max_scan #(
    .CNT_W  (CNT_W),
    .IDX_W  (IDX_W),
    .TIE_LOW(TIE_LOW)
  ) u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (state == SCAN),
    .first  (scan_idx == '0),
    .idx    (scan_idx),
    .val    (scan_val),
    .nxt_max(scan_max),
    .nxt_idx(scan_win),
    .nxt_tie(scan_tie)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      for (int c = 0; c < NUM_CAND; c++) tally[c] <= '0;
      voted         <= '0;
      spoiled_cnt   <= '0;
      dup_err       <= 1'b0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      scan_idx      <= '0;
      winner_onehot <= '0;
      winner_idx    <= '0;
      winner_votes  <= '0;
      tie           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= OPEN;
            busy         <= 1'b1;
            result_valid <= 1'b0;
            voted        <= '0;
            spoiled_cnt  <= '0;
            dup_err      <= 1'b0;
            for (int c = 0; c < NUM_CAND; c++) tally[c] <= '0;
          end else if ((state == DONE) && result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        OPEN: begin
          voted       <= voted | ballot_valid;
          spoiled_cnt <= spoiled_cnt + spoil_inc;
          for (int c = 0; c < NUM_CAND; c++) tally[c] <= tally[c] + inc[c];
          if (|(ballot_valid & voted)) dup_err <= 1'b1;
          if (close || all_cast) begin
            state    <= SCAN;
            scan_idx <= '0;
          end
        end
        SCAN: begin
          scan_idx <= scan_idx + IDX_W'(1);
          if (scan_last) begin
            state         <= DONE;
            busy          <= 1'b0;
            result_valid  <= 1'b1;
            winner_idx    <= scan_win;
            winner_votes  <= scan_max;
            tie           <= scan_tie;
            winner_onehot <= {{(NUM_CAND-1){1'b0}}, 1'b1} << scan_win;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vote_session_tally.sv
`default_nettype none
// ==== tb_vote_session_tally : table, directed and random checks of both tie rules -- rev 1.0 ====
module tb_vote_session_tally;

  localparam int NV = 5;
  localparam int NC = 3;
  localparam int CW = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          close = 1'b0;
  logic          result_ready = 1'b0;
  logic [NV-1:0] ballot_valid = '0;
  logic [NV*NC-1:0] ballot = '0;

  logic          busy0, rv0, tie0, dup0;
  logic [NC-1:0] oh0;
  logic [IW-1:0] idx0;
  logic [CW-1:0] votes0, sp0;
  logic          busy1, rv1, tie1, dup1;
  logic [NC-1:0] oh1;
  logic [IW-1:0] idx1;
  logic [CW-1:0] votes1, sp1;

  always #5 clk = ~clk;

  vote_session_tally #(.NUM_VOTERS(NV), .NUM_CAND(NC), .TIE_LOW(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .close(close),
    .ballot_valid(ballot_valid), .ballot(ballot), .busy(busy0),
    .result_valid(rv0), .result_ready(result_ready), .winner_onehot(oh0),
    .winner_idx(idx0), .winner_votes(votes0), .tie(tie0),
    .spoiled_cnt(sp0), .dup_err(dup0)
  );

  vote_session_tally #(.NUM_VOTERS(NV), .NUM_CAND(NC), .TIE_LOW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .close(close),
    .ballot_valid(ballot_valid), .ballot(ballot), .busy(busy1),
    .result_valid(rv1), .result_ready(result_ready), .winner_onehot(oh1),
    .winner_idx(idx1), .winner_votes(votes1), .tie(tie1),
    .spoiled_cnt(sp1), .dup_err(dup1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic step(input logic s, input logic c, input logic [NV-1:0] v,
                      input logic [NV*NC-1:0] b, input logic r);
    start = s; close = c; ballot_valid = v; ballot = b; result_ready = r;
    @(negedge clk);
  endtask

  // Reference model: plain per-voter bookkeeping and a final argmax.
  int m_tally [NC];
  bit m_voted [NV];
  int m_spoiled;
  bit m_dup;

  function automatic void model_clear();
    for (int c = 0; c < NC; c++) m_tally[c] = 0;
    for (int i = 0; i < NV; i++) m_voted[i] = 1'b0;
    m_spoiled = 0;
    m_dup = 1'b0;
  endfunction

  function automatic void model_ballots(input logic [NV-1:0] v, input logic [NV*NC-1:0] b);
    for (int i = 0; i < NV; i++) begin
      if (v[i]) begin
        logic [NC-1:0] x;
        x = b[i*NC +: NC];
        if (m_voted[i]) m_dup = 1'b1;
        else begin
          m_voted[i] = 1'b1;
          if ($countones(x) == 1) begin
            for (int c = 0; c < NC; c++) if (x[c]) m_tally[c]++;
          end else m_spoiled++;
        end
      end
    end
  endfunction

  function automatic bit model_all_voted();
    for (int i = 0; i < NV; i++) if (!m_voted[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_expect(input bit tl, output logic [NC-1:0] oh, output logic [IW-1:0] idx,
                              output logic [CW-1:0] votes, output logic t);
    int mx, cnt, w;
    mx = 0; cnt = 0; w = -1;
    for (int c = 0; c < NC; c++) if (m_tally[c] > mx) mx = m_tally[c];
    for (int c = 0; c < NC; c++) begin
      if (m_tally[c] == mx) begin
        cnt++;
        if (!tl || w < 0) w = c;
      end
    end
    oh = '0;
    oh[w] = 1'b1;
    idx = w[IW-1:0];
    votes = mx[CW-1:0];
    t = (cnt >= 2);
  endtask

  task automatic begin_session();
    step(1'b1, 1'b0, '0, '0, 1'b0);
    model_clear();
  endtask

  task automatic cast(input logic [NV-1:0] v, input logic [NV*NC-1:0] b, input logic c,
                      output bit ended);
    step(1'b0, c, v, b, 1'b0);
    model_ballots(v, b);
    ended = c || model_all_voted();
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 1;
    chk({tag, "_busy_scan"}, busy0, 1);
    while (!rv0 && n < 20) begin
      step(1'b0, 1'b0, '0, '0, 1'b0);
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_rv1"}, rv1, 1);
    chk({tag, "_busy_done"}, busy0, 0);
  endtask

  task automatic check_model(input string tag);
    logic [NC-1:0] e_oh;
    logic [IW-1:0] e_idx;
    logic [CW-1:0] e_votes;
    logic          e_tie;
    model_expect(1'b0, e_oh, e_idx, e_votes, e_tie);
    chk({tag, "_oh0"}, oh0, e_oh);
    chk({tag, "_idx0"}, idx0, e_idx);
    chk({tag, "_votes0"}, votes0, e_votes);
    chk({tag, "_tie0"}, tie0, e_tie);
    model_expect(1'b1, e_oh, e_idx, e_votes, e_tie);
    chk({tag, "_oh1"}, oh1, e_oh);
    chk({tag, "_idx1"}, idx1, e_idx);
    chk({tag, "_tie1"}, tie1, e_tie);
    chk({tag, "_spoiled"}, sp0, m_spoiled);
    chk({tag, "_dup"}, dup0, m_dup);
  endtask

  task automatic accept(input string tag);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    chk({tag, "_acc_rv0"}, rv0, 0);
    chk({tag, "_acc_rv1"}, rv1, 0);
    result_ready = 1'b0;
  endtask

  typedef struct {
    logic [NV-1:0]    v;
    logic [NV*NC-1:0] b;
    logic             c;
    logic [NC-1:0]    oh0;
    logic [IW-1:0]    i0;
    logic [NC-1:0]    oh1;
    logic [IW-1:0]    i1;
    logic [CW-1:0]    votes;
    logic             t;
    logic [CW-1:0]    sp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ended;
    logic [NV-1:0] rv;
    logic [NV*NC-1:0] rb;
    int ncyc;

    // Ballots listed as {voter4, voter3, voter2, voter1, voter0}.
    tbl[0] = '{5'b11111, {3'b001, 3'b100, 3'b001, 3'b010, 3'b001}, 1'b1,
               3'b001, 2'd0, 3'b001, 2'd0, 3'd3, 1'b0, 3'd0};
    tbl[1] = '{5'b11111, {3'b010, 3'b100, 3'b100, 3'b001, 3'b001}, 1'b0,
               3'b100, 2'd2, 3'b001, 2'd0, 3'd2, 1'b1, 3'd0};
    tbl[2] = '{5'b11111, {3'b000, 3'b010, 3'b011, 3'b010, 3'b010}, 1'b0,
               3'b010, 2'd1, 3'b010, 2'd1, 3'd3, 1'b0, 3'd2};
    tbl[3] = '{5'b00000, 15'd0, 1'b1,
               3'b100, 2'd2, 3'b001, 2'd0, 3'd0, 1'b1, 3'd0};
    tbl[4] = '{5'b11111, {3'b111, 3'b000, 3'b110, 3'b000, 3'b101}, 1'b0,
               3'b100, 2'd2, 3'b001, 2'd0, 3'd0, 1'b1, 3'd5};
    tbl[5] = '{5'b00011, {3'b000, 3'b000, 3'b000, 3'b100, 3'b100}, 1'b1,
               3'b100, 2'd2, 3'b100, 2'd2, 3'd2, 1'b0, 3'd0};

    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", busy0, 0);
    chk("reset_rv", rv0, 0);
    chk("reset_oh", oh0, 0);
    chk("reset_votes", votes0, 0);
    chk("reset_dup", dup0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      begin_session();
      chk({tag, "_busy_open"}, busy0, 1);
      cast(tbl[i].v, tbl[i].b, tbl[i].c, ended);
      wait_result(tag);
      chk({tag, "_oh0"}, oh0, tbl[i].oh0);
      chk({tag, "_idx0"}, idx0, tbl[i].i0);
      chk({tag, "_oh1"}, oh1, tbl[i].oh1);
      chk({tag, "_idx1"}, idx1, tbl[i].i1);
      chk({tag, "_votes0"}, votes0, tbl[i].votes);
      chk({tag, "_votes1"}, votes1, tbl[i].votes);
      chk({tag, "_tie0"}, tie0, tbl[i].t);
      chk({tag, "_tie1"}, tie1, tbl[i].t);
      chk({tag, "_spoiled"}, sp0, tbl[i].sp);
      accept(tag);
    end

    // Duplicate ballot from voter 1, then the remaining voters complete the roll.
    begin_session();
    cast(5'b00010, {3'b000, 3'b000, 3'b000, 3'b010, 3'b000}, 1'b0, ended);
    chk("dup_before", dup0, 0);
    cast(5'b00011, {3'b000, 3'b000, 3'b000, 3'b100, 3'b001}, 1'b0, ended);
    chk("dup_set", dup0, 1);
    chk("dup_still_open", busy0, 1);
    cast(5'b11100, {3'b100, 3'b001, 3'b001, 3'b000, 3'b000}, 1'b0, ended);
    wait_result("dup");
    chk("dup_oh0", oh0, 3'b001);
    chk("dup_votes0", votes0, 3);
    chk("dup_tie0", tie0, 0);
    chk("dup_flag", dup0, 1);
    accept("dup");

    // Backpressure: result must hold while ready is low; stray ballots ignored.
    begin_session();
    cast(5'b11111, {3'b001, 3'b100, 3'b001, 3'b010, 3'b001}, 1'b0, ended);
    wait_result("hold");
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 5'b11111, 15'($urandom), 1'b0);
      chk("hold_rv", rv0, 1);
      chk("hold_oh", oh0, 3'b001);
      chk("hold_votes", votes0, 3);
      chk("hold_dup", dup0, 0);
    end
    step(1'b0, 1'b0, '0, '0, 1'b1);
    chk("hold_acc_rv", rv0, 0);
    chk("hold_acc_busy", busy0, 0);
    chk("hold_keep_oh", oh0, 3'b001);
    chk("hold_keep_votes", votes0, 3);
    step(1'b0, 1'b1, 5'b11111, 15'h7fff, 1'b0);
    chk("idle_ignore_busy", busy0, 0);
    chk("idle_ignore_rv", rv0, 0);
    chk("idle_ignore_dup", dup0, 0);

    // Restart from DONE discards the pending result.
    begin_session();
    cast(5'b00101, {3'b000, 3'b000, 3'b011, 3'b000, 3'b010}, 1'b1, ended);
    wait_result("restart_a");
    chk("restart_a_spoiled", sp0, 1);
    begin_session();
    chk("restart_rv", rv0, 0);
    chk("restart_busy", busy0, 1);
    chk("restart_spoiled", sp0, 0);
    cast(5'b11111, {3'b010, 3'b100, 3'b100, 3'b001, 3'b001}, 1'b0, ended);
    wait_result("restart_b");
    check_model("restart_b");
    accept("restart_b");

    // Asynchronous reset in the middle of the scan.
    begin_session();
    cast(5'b00111, {3'b000, 3'b000, 3'b100, 3'b100, 3'b010}, 1'b1, ended);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_rv", rv0, 0);
    chk("arst_oh0", oh0, 0);
    chk("arst_oh1", oh1, 0);
    chk("arst_idx", idx0, 0);
    chk("arst_votes", votes0, 0);
    chk("arst_tie", tie0, 0);
    chk("arst_spoiled", sp0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin_session();
    cast(5'b11111, {3'b100, 3'b010, 3'b100, 3'b001, 3'b100}, 1'b0, ended);
    wait_result("arst_clean");
    check_model("arst_clean");
    accept("arst_clean");

    for (int s = 0; s < 60; s++) begin
      string tag;
      tag = $sformatf("rnd%0d", s);
      begin_session();
      ncyc = $urandom_range(1, 5);
      for (int k = 0; k < ncyc; k++) begin
        rv = NV'($urandom);
        for (int i = 0; i < NV; i++) begin
          if ($urandom_range(0, 3) == 0) rb[i*NC +: NC] = NC'($urandom_range(0, 7));
          else rb[i*NC +: NC] = NC'(1 << $urandom_range(0, NC - 1));
        end
        cast(rv, rb, (k == ncyc - 1) || ($urandom_range(0, 4) == 0), ended);
        if (ended) break;
      end
      wait_result(tag);
      check_model(tag);
      for (int d = $urandom_range(0, 3); d > 0; d--) step(1'b0, 1'b0, '0, '0, 1'b0);
      accept(tag);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
